// File: rtl/reset_sequencer_if.sv
// Reset sequencer request/response bundle.
// Purpose : groups the reset request inputs and the sequenced reset outputs of
//           reset_sequencer so the top level can pass them as one port.
// Signals : src_i          - raw asynchronous reset request lines
//           sw_reset_req_i - single-cycle software reset request
//           cause_clear_i  - clears the sticky reset cause
//           reset_o        - active-high staged resets, bit 0 released first
//           reset_busy_o   - high while the sequence is not running
//           led_reset_o    - registered copy of reset_busy_o for the LED
//           reset_cause_o  - sticky cause {power-on, software, sources}
// Modports: master drives requests and observes resets; slave is the sequencer.
interface reset_sequencer_if #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 3
);
    logic [NUM_SRC-1:0]    src_i;
    logic                  sw_reset_req_i;
    logic                  cause_clear_i;
    logic [NUM_STAGES-1:0] reset_o;
    logic                  reset_busy_o;
    logic                  led_reset_o;
    logic [NUM_SRC+1:0]    reset_cause_o;

    modport master (
        output src_i,
        output sw_reset_req_i,
        output cause_clear_i,
        input  reset_o,
        input  reset_busy_o,
        input  led_reset_o,
        input  reset_cause_o
    );

    modport slave (
        input  src_i,
        input  sw_reset_req_i,
        input  cause_clear_i,
        output reset_o,
        output reset_busy_o,
        output led_reset_o,
        output reset_cause_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-source reset sequencer.
// Purpose : synchronises, polarity-normalises and debounces NUM_SRC reset
//           requests plus a software request, holds reset for RESET_CLKS
//           cycles after all sources release, then drops NUM_STAGES resets
//           one after another, STAGE_GAP_CLKS cycles apart. Keeps a sticky
//           record of what caused the last reset.
// Ports   : clk_i     - module clock
//           reset_n_i - asynchronous active-low reset (power-on)
//           bus       - reset_sequencer_if slave modport (requests in,
//                       staged resets / busy / LED / cause out)
module reset_sequencer #(
    parameter int unsigned        NUM_SRC         = 2,
    parameter logic [NUM_SRC-1:0] SRC_ACTIVE_HIGH = 2'b01,
    parameter int unsigned        SYNC_STAGES     = 2,
    parameter int unsigned        DEBOUNCE_CLKS   = 4,
    parameter int unsigned        RESET_CLKS      = 7,
    parameter int unsigned        NUM_STAGES      = 3,
    parameter int unsigned        STAGE_GAP_CLKS  = 2
) (
    input logic             clk_i,
    input logic             reset_n_i,
    reset_sequencer_if.slave bus
);

    localparam int unsigned DebW  = $clog2((DEBOUNCE_CLKS > 2) ? DEBOUNCE_CLKS : 2);
    localparam int unsigned HoldW = $clog2((RESET_CLKS > 2) ? RESET_CLKS : 2);
    localparam int unsigned GapW  = $clog2((STAGE_GAP_CLKS > 2) ? STAGE_GAP_CLKS : 2);
    localparam int unsigned IdxW  = $clog2((NUM_STAGES > 2) ? NUM_STAGES : 2);

    typedef enum logic [2:0] {
        StAssert,
        StWaitRelease,
        StHold,
        StRelease,
        StRunning
    } state_e;

    // ---------------------------------------------------------------
    // Input path: synchroniser, polarity normalisation, debounce
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q [NUM_SRC];
    logic [NUM_SRC-1:0]     norm;
    logic [NUM_SRC-1:0]     deb_q, deb_d;
    logic [DebW-1:0]        deb_cnt_q [NUM_SRC];
    logic [DebW-1:0]        deb_cnt_d [NUM_SRC];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // Reset to the raw idle level so the normalised value starts deasserted.
            for (int i = 0; i < NUM_SRC; i++) begin
                sync_q[i]    <= {SYNC_STAGES{~SRC_ACTIVE_HIGH[i]}};
                deb_cnt_q[i] <= '0;
            end
            deb_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                sync_q[i]    <= {sync_q[i][SYNC_STAGES-2:0], bus.src_i[i]};
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            deb_q <= deb_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            norm[i]      = sync_q[i][SYNC_STAGES-1] ~^ SRC_ACTIVE_HIGH[i];
            deb_cnt_d[i] = deb_cnt_q[i];
            if (norm[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DebW'(DEBOUNCE_CLKS - 1)) begin
                // Last of DEBOUNCE_CLKS consecutive differing edges.
                deb_d[i]     = ~deb_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    state_e                state_q, state_d;
    logic [HoldW-1:0]      hold_q, hold_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NUM_STAGES-1:0] reset_q, reset_d;
    logic [NUM_SRC+1:0]    cause_q, cause_d;
    logic                  busy_q, busy_d;
    logic                  led_q;
    logic                  any_deb;

    assign any_deb = |deb_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StAssert;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            reset_q <= '1;
            cause_q <= {1'b1, {(NUM_SRC + 1){1'b0}}};
            busy_q  <= 1'b1;
            led_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            reset_q <= reset_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
            led_q   <= busy_q;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        reset_d = reset_q;
        // A trigger below overwrites this, so a coincident clear is discarded.
        cause_d = bus.cause_clear_i ? '0 : cause_q;

        case (state_q)
            StAssert: begin
                reset_d = '1;
                state_d = StWaitRelease;
            end

            StWaitRelease: begin
                if (!any_deb) begin
                    hold_d  = HoldW'(RESET_CLKS - 1);
                    state_d = StHold;
                end
            end

            StHold: begin
                if (any_deb) begin
                    reset_d = '1;
                    state_d = StAssert;
                    cause_d = cause_q | {2'b00, deb_q};
                end else if (hold_q == '0) begin
                    reset_d[0] = 1'b0;
                    if (NUM_STAGES == 1) begin
                        state_d = StRunning;
                    end else begin
                        gap_d   = GapW'(STAGE_GAP_CLKS - 1);
                        idx_d   = IdxW'(1);
                        state_d = StRelease;
                    end
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end

            StRelease: begin
                if (any_deb) begin
                    reset_d = '1;
                    state_d = StAssert;
                    cause_d = cause_q | {2'b00, deb_q};
                end else if (gap_q == '0) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            reset_d[k] = 1'b0;
                        end
                    end
                    if (idx_q == IdxW'(NUM_STAGES - 1)) begin
                        state_d = StRunning;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                        gap_d = GapW'(STAGE_GAP_CLKS - 1);
                    end
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end

            StRunning: begin
                reset_d = '0;
                if (any_deb || bus.sw_reset_req_i) begin
                    reset_d = '1;
                    state_d = StAssert;
                    cause_d = {1'b0, bus.sw_reset_req_i, deb_q};
                end
            end

            default: begin
                reset_d = '1;
                state_d = StAssert;
            end
        endcase

        busy_d = (state_d != StRunning);
    end

    assign bus.reset_o       = reset_q;
    assign bus.reset_busy_o  = busy_q;
    assign bus.led_reset_o   = led_q;
    assign bus.reset_cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed timing checks plus randomized
// request traffic compared every cycle against a behavioural model.
module tb_reset_sequencer;

    localparam int NS   = 2;
    localparam int NST  = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RCLK = 7;
    localparam int GAP  = 2;
    localparam logic [NS-1:0] AH   = 2'b01;
    localparam logic [NS-1:0] IDLE = ~AH;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_SRC(NS), .NUM_STAGES(NST)) bus ();

    reset_sequencer #(
        .NUM_SRC        (NS),
        .SRC_ACTIVE_HIGH(AH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CLKS  (DEB),
        .RESET_CLKS     (RCLK),
        .NUM_STAGES     (NST),
        .STAGE_GAP_CLKS (GAP)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: a source counts as asserted once its input,
    // seen SYNC edges late, has differed from the debounced level on the
    // last DEB edges. The sequence is timed as elapsed edges since the
    // sources cleared: stage k is released after RCLK + k*GAP edges.
    // ---------------------------------------------------------------
    typedef enum {MAssert, MWait, MSeq, MRun} mmode_e;

    logic [NS-1:0]   m_pipe[$];
    logic [NS-1:0]   m_hist[$];
    logic [NS-1:0]   m_deb;
    mmode_e          m_mode;
    int              m_t;
    logic [NS+1:0]   m_cause;
    logic            m_busy, m_led;

    function automatic logic [NST-1:0] m_reset_o();
        logic [NST-1:0] r;
        r = '1;
        if (m_mode == MRun) r = '0;
        else if (m_mode == MSeq)
            for (int k = 0; k < NST; k++) r[k] = (m_t < RCLK + k * GAP);
        return r;
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int s = 0; s < SYNC; s++) m_pipe.push_back(IDLE);
        m_hist.delete();
        m_deb   = '0;
        m_mode  = MAssert;
        m_t     = 0;
        m_cause = '0;
        m_cause[NS+1] = 1'b1;
        m_busy  = 1'b1;
        m_led   = 1'b1;
    endtask

    task automatic model_step(input logic [NS-1:0] src, input logic sw, input logic clr);
        logic [NS-1:0] n, nd;
        logic [NS+1:0] cause_n;
        logic          all_diff;
        n = m_pipe.pop_front() ~^ AH;
        m_pipe.push_back(src);
        cause_n = clr ? '0 : m_cause;
        case (m_mode)
            MAssert: m_mode = MWait;
            MWait: if (m_deb == '0) begin m_mode = MSeq; m_t = 0; end
            MSeq: begin
                if (m_deb != '0) begin
                    m_mode  = MAssert;
                    cause_n = m_cause | {2'b00, m_deb};
                end else begin
                    m_t++;
                    if (m_t >= RCLK + (NST - 1) * GAP) m_mode = MRun;
                end
            end
            default: begin
                if (m_deb != '0 || sw) begin
                    m_mode  = MAssert;
                    cause_n = {1'b0, sw, m_deb};
                end
            end
        endcase
        m_cause = cause_n;
        m_led   = m_busy;
        m_busy  = (m_mode != MRun);
        m_hist.push_back(n);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        nd = m_deb;
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < NS; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) nd[i] = ~m_deb[i];
            end
        end
        m_deb = nd;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step(bus.src_i, bus.sw_reset_req_i, bus.cause_clear_i);
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check_value("cyc_reset_o", 32'(bus.reset_o), 32'(m_reset_o()));
            check_value("cyc_busy", 32'(bus.reset_busy_o), 32'(m_busy));
            check_value("cyc_led", 32'(bus.led_reset_o), 32'(m_led));
            check_value("cyc_cause", 32'(bus.reset_cause_o), 32'(m_cause));
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic wait_running(input int limit);
        int k;
        k = 0;
        while (bus.reset_busy_o && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (bus.reset_busy_o) check_value("run_timeout", 32'(bus.reset_busy_o), 32'd0);
    endtask

    task automatic pulse_sw();
        bus.sw_reset_req_i = 1'b1;
        @(negedge clk);
        bus.sw_reset_req_i = 1'b0;
    endtask

    int f0, f1, f2, fb, fl, n;

    initial begin
        reset_n            = 1'b0;
        bus.src_i          = IDLE;
        bus.sw_reset_req_i = 1'b0;
        bus.cause_clear_i  = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_reset_o", 32'(bus.reset_o), 32'h7);
        check_value("rst_busy", 32'(bus.reset_busy_o), 32'h1);
        reset_n = 1'b1;

        // Power-on release timing, counted in edges after reset_n rises.
        f0 = 0; f1 = 0; f2 = 0; fb = 0; fl = 0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (f0 == 0 && !bus.reset_o[0]) f0 = e;
            if (f1 == 0 && !bus.reset_o[1]) f1 = e;
            if (f2 == 0 && !bus.reset_o[2]) f2 = e;
            if (fb == 0 && !bus.reset_busy_o) fb = e;
            if (fl == 0 && !bus.led_reset_o) fl = e;
        end
        check_value("por_r0_fall", f0, 9);
        check_value("por_r1_fall", f1, 11);
        check_value("por_r2_fall", f2, 13);
        check_value("por_busy_fall", fb, 13);
        check_value("por_led_fall", fl, 14);
        check_value("por_cause", 32'(bus.reset_cause_o), 32'h8);

        // Short glitch is filtered.
        bus.src_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus.src_i[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_value("glitch_reset_o", 32'(bus.reset_o), 32'h0);
        check_value("glitch_cause", 32'(bus.reset_cause_o), 32'h8);

        // Long active-high request: assertion latency then cause.
        bus.src_i[0] = 1'b1;
        n = 0;
        while (n < 20 && bus.reset_o != 3'b111) begin
            @(negedge clk);
            n++;
        end
        check_value("src0_latency", n, 7);
        repeat (50 - n) @(negedge clk);
        bus.src_i[0] = 1'b0;
        wait_running(200);
        check_value("src0_cause", 32'(bus.reset_cause_o), 32'h1);

        // Active-low source.
        bus.src_i[1] = 1'b0;
        repeat (10) @(negedge clk);
        check_value("src1_reset_o", 32'(bus.reset_o), 32'h7);
        bus.src_i[1] = 1'b1;
        wait_running(200);
        check_value("src1_cause", 32'(bus.reset_cause_o), 32'h2);
        repeat (30) @(negedge clk);
        check_value("src1_idle_high", 32'(bus.reset_o), 32'h0);

        // Software request; second pulse during HOLD ignored.
        pulse_sw();
        check_value("sw_reset_o", 32'(bus.reset_o), 32'h7);
        check_value("sw_cause", 32'(bus.reset_cause_o), 32'h4);
        n = 0;
        while (n < 40 && bus.reset_busy_o) begin
            @(negedge clk);
            n++;
            bus.sw_reset_req_i = (n == 4);
        end
        bus.sw_reset_req_i = 1'b0;
        check_value("sw_seq_len", n, 13);

        // Retrigger while stages are being released.
        pulse_sw();
        repeat (4) @(negedge clk);
        bus.src_i[0] = 1'b1;
        repeat (6) @(negedge clk);
        check_value("mid_partial", 32'(bus.reset_o), 32'h6);
        @(negedge clk);
        check_value("mid_retrig", 32'(bus.reset_o), 32'h7);
        check_value("mid_cause", 32'(bus.reset_cause_o), 32'h5);
        repeat (8) @(negedge clk);
        bus.src_i[0] = 1'b0;
        wait_running(200);
        check_value("mid_cause_end", 32'(bus.reset_cause_o), 32'h5);

        // Cause clear, alone and with a coincident trigger.
        bus.cause_clear_i = 1'b1;
        @(negedge clk);
        bus.cause_clear_i = 1'b0;
        check_value("clear_cause", 32'(bus.reset_cause_o), 32'h0);
        bus.cause_clear_i = 1'b1;
        pulse_sw();
        bus.cause_clear_i = 1'b0;
        check_value("clear_vs_trig", 32'(bus.reset_cause_o), 32'h4);
        wait_running(200);

        // Randomized traffic; the per-cycle model check does the work here.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(1, 30)) @(negedge clk);
                1: begin
                    bus.src_i[0] = 1'b1;
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    bus.src_i[0] = 1'b0;
                end
                2: begin
                    bus.src_i[1] = 1'b0;
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    bus.src_i[1] = 1'b1;
                end
                3: pulse_sw();
                4: begin
                    bus.cause_clear_i = 1'b1;
                    @(negedge clk);
                    bus.cause_clear_i = 1'b0;
                end
                default: begin
                    repeat ($urandom_range(1, 20)) begin
                        bus.src_i          = NS'($urandom_range(0, 3));
                        bus.sw_reset_req_i = ($urandom_range(0, 5) == 0);
                        bus.cause_clear_i  = ($urandom_range(0, 7) == 0);
                        @(negedge clk);
                    end
                    bus.src_i          = IDLE;
                    bus.sw_reset_req_i = 1'b0;
                    bus.cause_clear_i  = 1'b0;
                end
            endcase
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        bus.src_i = IDLE;
        wait_running(400);
        check_value("final_reset_o", 32'(bus.reset_o), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
